// File: rtl/start_ctrl.sv
// start_ctrl: panel start controller issuing start pulses to the pulse
// distributor in single-step or continuous (rate-gapped) mode.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   run/stop/step_btn_from_panel raw asynchronous panel buttons
//   mode_from_panel [1:0]       00 halt, 01 step, 10 continuous, 11 halt
//   rate_from_panel [7:0]       continuous gap: one start per rate+1 cycles
//   halt_from_op                one-cycle halt from the halt instruction
//   clear_count_from_panel      one-cycle start-counter clear
//   start_pulse_to_pulse        one-cycle start pulse
//   running_to_panel            high while in RUN
//   start_count_to_panel        number of start pulses issued (wraps)
// Build option: define START_CTRL_DEBOUNCE_EN to add a per-button
// debounce filter of DEBOUNCE_CYCLES consecutive equal samples.
module start_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               run_btn_from_panel,
    input  logic               stop_btn_from_panel,
    input  logic               step_btn_from_panel,
    input  logic [1:0]         mode_from_panel,
    input  logic [7:0]         rate_from_panel,
    input  logic               halt_from_op,
    input  logic               clear_count_from_panel,
    output logic               start_pulse_to_pulse,
    output logic               running_to_panel,
    output logic [COUNT_W-1:0] start_count_to_panel
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Button vector bit order: 0 run, 1 stop, 2 step.
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] lvl;
    logic [2:0] lvl_d;
    logic [2:0] ev;

    assign raw = {step_btn_from_panel, stop_btn_from_panel,
                  run_btn_from_panel};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef START_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DW-1:0] db_cnt [3];
    logic [2:0]    db_lvl;

    // Counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_lvl <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = db_lvl;
`else
    logic unused_db;
    assign unused_db = |DEBOUNCE_CYCLES;
    assign lvl = sync2;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lvl_d <= '0;
        else         lvl_d <= lvl;
    end

    assign ev = lvl & ~lvl_d;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] gap_q;
    logic [7:0] gap_d;
    logic       step_q;
    logic       step_d;
    logic       run_pulse;
    logic       exit_run;

    assign exit_run = ev[1] | halt_from_op | (mode_from_panel != 2'b10);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gap_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        step_d    = 1'b0;
        run_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ev[0] && mode_from_panel == 2'b10) begin
                    state_d = RUN;
                    gap_d   = rate_from_panel;
                end else if (ev[2] && mode_from_panel == 2'b01) begin
                    step_d = 1'b1;
                end
            end
            RUN: begin
                // Leaving RUN wins over a pulse due in the same cycle.
                if (exit_run) begin
                    state_d = IDLE;
                end else if (gap_q == 8'd0) begin
                    run_pulse = 1'b1;
                    gap_d     = rate_from_panel;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_pulse_to_pulse = step_q | run_pulse;
    assign running_to_panel     = (state_q == RUN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_count_to_panel <= '0;
        end else if (clear_count_from_panel) begin
            start_count_to_panel <= COUNT_W'(start_pulse_to_pulse);
        end else if (start_pulse_to_pulse) begin
            start_count_to_panel <= start_count_to_panel + 1'b1;
        end
    end

endmodule

// File: tb/tb_start_ctrl.sv
// tb_start_ctrl: directed self-checking bench for start_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_start_ctrl;

`ifdef START_CTRL_DEBOUNCE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 0;
`endif
    localparam int HOLD = 5 + LAT;

    logic        clk;
    logic        resetn;
    logic        run_btn;
    logic        stop_btn;
    logic        step_btn;
    logic [1:0]  mode;
    logic [7:0]  rate;
    logic        halt;
    logic        clear;
    logic        pulse;
    logic        running;
    logic [15:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    start_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .COUNT_W(16)
    ) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .run_btn_from_panel    (run_btn),
        .stop_btn_from_panel   (stop_btn),
        .step_btn_from_panel   (step_btn),
        .mode_from_panel       (mode),
        .rate_from_panel       (rate),
        .halt_from_op          (halt),
        .clear_count_from_panel(clear),
        .start_pulse_to_pulse  (pulse),
        .running_to_panel      (running),
        .start_count_to_panel  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic settle();
        repeat (LAT + 6) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulse: got %b want 0", pulse);
        end
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_running: got %b want 0", running);
        end
        n_checks++;
        if (count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        @(negedge clk);
        resetn = 1'b1;
        settle();
    endtask

    task automatic test_step();
        int np = 0;
        int pk = -1;
        bit rs = 0;
        mode = 2'b01;
        @(negedge clk);
        step_btn = 1'b1;
        for (int k = 1; k <= 20 + LAT; k++) begin
            @(negedge clk);
            if (k == HOLD) step_btn = 1'b0;
            #1;
            if (pulse) begin
                np++;
                pk = k;
            end
            if (running) rs = 1;
        end
        n_checks++;
        if (np != 1) begin
            n_fail++;
            $display("FAIL step_pulses: got %0d want 1", np);
        end
        n_checks++;
        if (pk != 3 + LAT) begin
            n_fail++;
            $display("FAIL step_latency: got %0d want %0d", pk, 3 + LAT);
        end
        n_checks++;
        if (count !== 16'd1) begin
            n_fail++;
            $display("FAIL step_count: got %0d want 1", count);
        end
        n_checks++;
        if (rs) begin
            n_fail++;
            $display("FAIL step_running: got 1 want 0");
        end
        settle();
    endtask

    task automatic test_ignored_modes();
        int np = 0;
        bit rs = 0;
        for (int m = 0; m < 2; m++) begin
            mode = (m == 0) ? 2'b00 : 2'b10;
            @(negedge clk);
            step_btn = 1'b1;
            for (int k = 1; k <= 20 + LAT; k++) begin
                @(negedge clk);
                if (k == HOLD) step_btn = 1'b0;
                #1;
                if (pulse) np++;
                if (running) rs = 1;
            end
        end
        n_checks++;
        if (np != 0 || rs) begin
            n_fail++;
            $display("FAIL ignored_step: pulses %0d running %b want 0 0",
                     np, rs);
        end
        n_checks++;
        if (count !== 16'd1) begin
            n_fail++;
            $display("FAIL ignored_count: got %0d want 1", count);
        end
        settle();
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_checks++;
        if (count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_count: got %0d want 0", count);
        end
    endtask

    task automatic test_rate3();
        int np = 0;
        int pos [4];
        mode = 2'b10;
        rate = 8'd3;
        @(negedge clk);
        run_btn = 1'b1;
        for (int k = 1; k <= 16 + LAT; k++) begin
            @(negedge clk);
            if (k == HOLD) run_btn = 1'b0;
            #1;
            if (pulse) begin
                if (np < 4) pos[np] = k;
                np++;
            end
            if (k == 2 + LAT && running !== 1'b0) begin
                n_fail++;
                $display("FAIL rate3_early_run: got 1 want 0");
            end
            if (k == 3 + LAT) begin
                n_checks++;
                if (running !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rate3_running: got %b want 1", running);
                end
            end
        end
        n_checks++;
        if (np != 3) begin
            n_fail++;
            $display("FAIL rate3_pulses: got %0d want 3", np);
        end else begin
            n_checks++;
            if (pos[0] != 6 + LAT || pos[1] != 10 + LAT
                || pos[2] != 14 + LAT) begin
                n_fail++;
                $display("FAIL rate3_pos: got %0d %0d %0d want %0d %0d %0d",
                         pos[0], pos[1], pos[2],
                         6 + LAT, 10 + LAT, 14 + LAT);
            end
        end
        n_checks++;
        if (count !== 16'd3) begin
            n_fail++;
            $display("FAIL rate3_count: got %0d want 3", count);
        end
        @(negedge clk);
        stop_btn = 1'b1;
        for (int k = 1; k <= 10 + LAT; k++) begin
            @(negedge clk);
            if (k == HOLD) stop_btn = 1'b0;
        end
        #1;
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_running: got %b want 0", running);
        end
        settle();
    endtask

    task automatic test_halt_rate0();
        int run_len = 0;
        mode = 2'b10;
        rate = 8'd0;
        @(negedge clk);
        run_btn = 1'b1;
        for (int k = 1; k <= HOLD + 2; k++) begin
            @(negedge clk);
            if (k == HOLD) run_btn = 1'b0;
            #1;
            if (k >= 5 + LAT && pulse) run_len++;
        end
        n_checks++;
        if (running !== 1'b1 || run_len != 3) begin
            n_fail++;
            $display("FAIL rate0_run: running %b pulses %0d want 1 3",
                     running, run_len);
        end
        @(negedge clk);
        halt = 1'b1;
        #1;
        n_checks++;
        if (pulse !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_cycle: pulse %b running %b want 0 1",
                     pulse, running);
        end
        @(negedge clk);
        halt = 1'b0;
        #1;
        n_checks++;
        if (running !== 1'b0 || pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_idle: running %b pulse %b want 0 0",
                     running, pulse);
        end
        settle();
    endtask

    task automatic test_wrap();
        bit found = 0;
        mode = 2'b10;
        rate = 8'd0;
        @(negedge clk);
        run_btn = 1'b1;
        for (int k = 1; k <= 70000 + LAT; k++) begin
            @(negedge clk);
            if (k == HOLD) run_btn = 1'b0;
            #1;
            if (count == 16'hFFFF) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (!found || pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_reach: found %b pulse %b want 1 1",
                     found, pulse);
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_checks++;
        if (count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h want 0000", count);
        end
        n_checks++;
        if (pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_clear_pulse: got %b want 1", pulse);
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_checks++;
        if (count !== 16'h0001) begin
            n_fail++;
            $display("FAIL clear_with_pulse: got %h want 0001", count);
        end
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        #1;
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_halt: got %b want 0", running);
        end
        settle();
    endtask

    task automatic test_reset_mid_run();
        bit seen = 0;
        int np = 0;
        bit rs = 0;
        mode = 2'b10;
        rate = 8'd2;
        @(negedge clk);
        run_btn = 1'b1;
        for (int k = 1; k <= HOLD + 10; k++) begin
            @(negedge clk);
            if (k == HOLD) run_btn = 1'b0;
            #1;
            if (k > HOLD && pulse) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen || running !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_setup: pulse %b running %b want 1 1",
                     seen, running);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (pulse !== 1'b0 || running !== 1'b0 || count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: pulse %b running %b count %0d want 0",
                     pulse, running, count);
        end
        #1;
        resetn = 1'b1;
        for (int k = 0; k < 20 + LAT; k++) begin
            @(negedge clk);
            #1;
            if (pulse) np++;
            if (running) rs = 1;
        end
        n_checks++;
        if (np != 0 || rs) begin
            n_fail++;
            $display("FAIL midrun_restart: pulses %0d running %b want 0 0",
                     np, rs);
        end
        settle();
    endtask

`ifdef START_CTRL_DEBOUNCE_EN
    task automatic test_debounce();
        int np = 0;
        mode = 2'b01;
        @(negedge clk);
        step_btn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) step_btn = 1'b0;
            #1;
            if (pulse) np++;
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL debounce_glitch: got %0d want 0", np);
        end
        np = 0;
        @(negedge clk);
        step_btn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 20) step_btn = 1'b0;
            #1;
            if (pulse) np++;
        end
        n_checks++;
        if (np != 1) begin
            n_fail++;
            $display("FAIL debounce_press: got %0d want 1", np);
        end
        settle();
    endtask
`endif

    initial begin
        resetn   = 1'b0;
        run_btn  = 1'b0;
        stop_btn = 1'b0;
        step_btn = 1'b0;
        mode     = 2'b00;
        rate     = 8'd0;
        halt     = 1'b0;
        clear    = 1'b0;
        test_reset();
        test_step();
        test_ignored_modes();
        test_clear();
        test_rate3();
        test_clear();
        test_halt_rate0();
        test_clear();
        test_wrap();
        test_reset_mid_run();
`ifdef START_CTRL_DEBOUNCE_EN
        test_debounce();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/start_ctrl.md
START_CTRL -- requirements
Module: start_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles required to accept a button level (used only with the debounce feature).
REQ-002 The block SHALL have parameter COUNT_W, default 16, giving the width of the issued-start counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port run_btn_from_panel  input  1  raw asynchronous run button.
REQ-006 The block SHALL have port stop_btn_from_panel  input  1  raw asynchronous stop button.
REQ-007 The block SHALL have port step_btn_from_panel  input  1  raw asynchronous single-step button.
REQ-008 The block SHALL have port mode_from_panel  input  2  mode: 00 halt, 01 step, 10 continuous, 11 treated as halt.
REQ-009 The block SHALL have port rate_from_panel  input  8  continuous-mode gap; one start every rate+1 cycles.
REQ-010 The block SHALL have port halt_from_op  input  1  synchronous one-cycle pulse from the halt instruction.
REQ-011 The block SHALL have port clear_count_from_panel  input  1  synchronous one-cycle counter clear.
REQ-012 The block SHALL have port start_pulse_to_pulse  output  1  one-cycle start pulse to the pulse distributor.
REQ-013 The block SHALL have port running_to_panel  output  1  level, high while in RUN.
REQ-014 The block SHALL have port start_count_to_panel  output  COUNT_W  count of start pulses issued.

Function
REQ-015 Each raw button SHALL pass through a two-flop synchronizer followed by a rising-edge detector producing a one-cycle event; a step event is therefore detected no earlier than the third rising clock edge after the raw rise.
REQ-016 The FSM SHALL have exactly two states, IDLE and RUN; running_to_panel = (state == RUN).
REQ-017 In IDLE, a step event with mode 01 SHALL assert start_pulse_to_pulse for exactly one cycle, in the cycle after the event; the state stays IDLE.
REQ-018 In IDLE, a run event with mode 10 SHALL move to RUN and load the gap counter with rate_from_panel.
REQ-019 In IDLE, run events in other modes and step events in modes other than 01 SHALL be ignored.
REQ-020 In RUN, the gap counter SHALL decrement each cycle while nonzero; in a cycle where it equals 0, start_pulse_to_pulse SHALL be asserted and the counter reloaded from the current rate_from_panel.
REQ-021 rate 0 SHALL give a pulse every RUN cycle; rate N SHALL give the first pulse N cycles after entering RUN and then one pulse every N+1 cycles.
REQ-022 In RUN, a stop event, halt_from_op, or mode != 10 SHALL return the FSM to IDLE at the next edge.
REQ-023 An exit condition in REQ-022 SHALL suppress any start pulse due in the same cycle.
REQ-024 In RUN, run and step events SHALL be ignored.
REQ-025 start_count_to_panel SHALL increment once per issued start pulse and wrap from all-ones to 0.
REQ-026 When clear and a pulse occur in the same cycle, start_count_to_panel SHALL become 1.
REQ-027 start_pulse_to_pulse SHALL never be high for two consecutive cycles unless in RUN with rate 0.

Reset
REQ-028 While resetn is low, the block SHALL asynchronously force state IDLE, gap counter 0, start_count_to_panel 0, start_pulse_to_pulse 0, running_to_panel 0, synchronizer and edge flops 0, and debounce counters 0.
REQ-029 A reset asserted mid-RUN SHALL drop any in-flight pulse immediately; after release, the block SHALL require a fresh run event.

Configuration
REQ-030 With START_CTRL_DEBOUNCE_EN defined, each synchronized button SHALL be accepted as a new level only after DEBOUNCE_CYCLES consecutive equal samples, and edge detection SHALL act on the accepted level, adding DEBOUNCE_CYCLES cycles of latency.
REQ-031 With START_CTRL_DEBOUNCE_EN undefined, edge detection SHALL act directly on the synchronizer output, with no filter logic.

Verification
REQ-032 Reset, mode 01, step pulsed high 5 cycles -> exactly one start pulse, start_count_to_panel = 1, running_to_panel stays 0.
REQ-033 Mode 10, rate 3, run event -> pulses on RUN cycles 3, 7, 11; after 3 pulses, count = 3.
REQ-034 Mode 10, rate 0, run, then halt_from_op in a pulse cycle -> that cycle has no pulse, next cycle IDLE, running = 0.
REQ-035 Count preset to 0xFFFF via pulses, one more pulse -> 0x0000; clear coincident with a pulse -> 0x0001.
REQ-036 resetn low mid-RUN for 1 ns between edges -> outputs 0 immediately; after release, no pulses until a new run event.
REQ-037 With START_CTRL_DEBOUNCE_EN, a 10-cycle step glitch (DEBOUNCE_CYCLES = 16) -> no pulse; a 20-cycle press -> one pulse.
